tlb_op_ctrl: RTL and testbench
==============================

# tlb_op_ctrl

Sequencer for TLB maintenance instructions (tlbsrch, tlbrd, tlbwr, tlbfill, invtlb) in the five-stage LoongArch pipeline. Accepts one op at a time from the write-back stage and drives the TLB read, write, invalidate and s1 search ports. Arbitrates the single s1 search port between maintenance ops and data-access translation from EXE. Owns the tlbfill replacement index and issues the post-op refetch flush.

## Interface
- `TLBNUM`, 16, TLB entries; `IW = $clog2(TLBNUM)` derived
- `clk` in 1 — single clock
- `resetn` in 1 — asynchronous, active-low reset
- `op_valid` in 1 — maintenance op request
- `op_ready` out 1 — high only in IDLE
- `op_type` in 3 — op code, see package
- `op_invop` in 5 — invtlb op field
- `op_asid` in 10, `op_vppn` in 19, `op_va_bit12` in 1 — search/invalidate key
- `op_pc` in 32 — PC of the op instruction
- `csr_tlbidx_index` in IW — TLBIDX.Index
- `ex_flush` in 1 — exception/ertn flush from WB
- `mem_req` in 1, `mem_vppn` in 19, `mem_va_bit12` in 1, `mem_asid` in 10 — EXE data translation
- `mem_grant` out 1 — s1 port granted to EXE this cycle
- `s1_vppn` out 19, `s1_va_bit12` out 1, `s1_asid` out 10 — TLB s1 port
- `s1_found` in 1, `s1_index` in IW — combinational TLB search result
- `r_index` out IW — TLB read index
- `tlb_we` out 1, `w_index` out IW — TLB write strobe and index
- `invtlb_valid` out 1, `invtlb_op` out 5
- `op_done` out 1 — one-cycle completion pulse
- `srch_hit` out 1, `srch_index` out IW — tlbsrch result, valid with `op_done`
- `refetch` out 1, `refetch_pc` out 32 — pipeline refetch request

## Operation
- States: IDLE, SRCH, RD, WR, INV, FLUSH. Ops latched on `op_valid & op_ready & ~ex_flush`.
- IDLE → SRCH/RD/WR(for WR and FILL)/INV by latched type. Codes 0, 6, 7: accepted and dropped, no strobes, no `op_done`.
- SRCH (1 cycle): s1 driven from latched key; `s1_found`/`s1_index` captured into `srch_hit`/`srch_index`; `op_done` pulses; → IDLE. No refetch.
- RD (1 cycle): `r_index = csr_tlbidx_index`; `op_done`; → FLUSH.
- WR (1 cycle): `tlb_we=1`; `w_index = csr_tlbidx_index` for tlbwr, fill index for tlbfill; `op_done`; → FLUSH.
- INV (1 cycle): `invtlb_valid=1`, `invtlb_op=op_invop`, s1 driven from latched key; `op_done`; → FLUSH.
- FLUSH (1 cycle): `refetch=1`, `refetch_pc = op_pc + 4` (mod 2^32); → IDLE.
- s1 arbitration: SRCH/INV own the port, `mem_grant=0`; otherwise s1 = mem fields, `mem_grant = mem_req`.
- `ex_flush` in any non-IDLE state: that cycle's `tlb_we`/`invtlb_valid`/`op_done`/`refetch` forced 0; → IDLE.
- Fill index: IW-bit free-running counter, +1 every cycle, wraps TLBNUM-1 → 0; value sampled in the WR cycle.

## Timing
- Acceptance at cycle N → op strobe and `op_done` at N+1 → `refetch` at N+2 (not for SRCH); `op_ready` high again at N+2 (SRCH) or N+3.
- `mem_req` in the acceptance cycle is still granted; denied only during SRCH/INV cycles.
- Reset values: FSM IDLE, `op_ready=1`, all strobes/`op_done`/`refetch`/`srch_hit` 0, `srch_index`/`w_index`/`r_index` 0, `refetch_pc` 0, fill counter 0. Reset mid-op aborts with no strobe.
- `srch_hit`/`srch_index` hold until the next SRCH.

## Configuration
- `TLB_FILL_LFSR_EN`: defined → fill index is an IW-bit maximal LFSR (reset seed 1, never 0 for IW≥2), stepped every cycle; undefined → plain wrapping counter as above.

## Structure
- Package `tlb_pkg`: op codes `TLBOP_SRCH=1, TLBOP_RD=2, TLBOP_WR=3, TLBOP_FILL=4, TLBOP_INV=5`; state enum; vppn/asid widths.
- Sub-module `tlb_fill_idx` (counter/LFSR selected by macro).

## Test plan
- tlbsrch, key vppn 0x12345/asid 0x3, TLB model hits at 7 → `op_done` at N+1, `srch_hit=1`, `srch_index=7`, no `refetch`.
- tlbwr, `csr_tlbidx_index=5`, `op_pc=0x1c000100` → `tlb_we`,`w_index=5` at N+1; `refetch`, `refetch_pc=0x1c000104` at N+2.
- tlbfill two ops 3 cycles apart (counter mode) → `w_index` values differ by 3 mod 16; wrap 15→0 observed.
- invtlb op 5 with `mem_req=1` held → `mem_grant=0` only in INV cycle, `invtlb_op=5`.
- tlbwr accepted, `ex_flush=1` at N+1 → no `tlb_we`, no `op_done`, no `refetch`, `op_ready=1` at N+2.
- `resetn` low mid-RD → all outputs at reset values immediately; first op after release completes normally.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB maintenance-op sequencer: op codes, FSM state
// encoding, key widths and the LFSR tap table used by tlb_fill_idx.
package tlb_pkg;

   localparam int unsigned VPPN_W = 19;
   localparam int unsigned ASID_W = 10;
   localparam int unsigned OP_W   = 3;

   // Codes 0, 6 and 7 are not maintenance ops; the sequencer accepts and drops them.
   localparam logic [OP_W-1:0] TLBOP_SRCH = 3'd1;
   localparam logic [OP_W-1:0] TLBOP_RD   = 3'd2;
   localparam logic [OP_W-1:0] TLBOP_WR   = 3'd3;
   localparam logic [OP_W-1:0] TLBOP_FILL = 3'd4;
   localparam logic [OP_W-1:0] TLBOP_INV  = 3'd5;

   typedef enum logic [2:0] {
      StIdle,
      StSrch,
      StRd,
      StWr,
      StInv,
      StFlush
   } tlb_state_e;

   // Fibonacci tap masks (bit i = stage i+1) for maximal-length LFSRs, widths 2..10.
   function automatic logic [31:0] lfsr_taps(input int unsigned width);
      logic [31:0] taps;
      case (width)
         2:       taps = 32'h0000_0003;
         3:       taps = 32'h0000_0006;
         4:       taps = 32'h0000_000c;
         5:       taps = 32'h0000_0014;
         6:       taps = 32'h0000_0030;
         7:       taps = 32'h0000_0060;
         8:       taps = 32'h0000_00b8;
         9:       taps = 32'h0000_0110;
         10:      taps = 32'h0000_0240;
         default: taps = 32'h0000_0000;
      endcase
      return taps;
   endfunction

endpackage

// File: rtl/tlb_fill_idx.sv
// Replacement index source for tlbfill. Steps every cycle; the sequencer samples
// it in the write cycle.
// Build option TLB_FILL_LFSR_EN: defined -> IW-bit maximal LFSR (seed 1, widths
// 2..10); undefined -> counter wrapping TLBNUM-1 -> 0.
module tlb_fill_idx
   import tlb_pkg::*;
#(
   parameter int unsigned TLBNUM = 16,
   parameter int unsigned IW     = $clog2(TLBNUM)
) (
   input  logic          clk,
   input  logic          resetn,
   output logic [IW-1:0] idx
);

`ifdef TLB_FILL_LFSR_EN
   logic [IW-1:0] lfsr_q;
   logic [IW-1:0] lfsr_d;

   generate
      if (IW >= 2) begin : g_lfsr
         localparam logic [31:0] Taps = lfsr_taps(IW);
         // Shift left, XOR of tapped stages enters at bit 0.
         always_comb begin
            lfsr_d = {lfsr_q[IW-2:0], ^(lfsr_q & Taps[IW-1:0])};
         end
      end else begin : g_toggle
         // A single-bit "LFSR" degenerates to a toggle.
         always_comb begin
            lfsr_d = ~lfsr_q;
         end
      end
   endgenerate

   // LFSR state; seeded non-zero so it never locks up.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lfsr_q <= IW'(1);
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign idx = lfsr_q;
`else
   logic [IW-1:0] cnt_q;
   logic [IW-1:0] cnt_d;

   // Wrap explicitly so non-power-of-two TLBNUM stays in range.
   always_comb begin
      cnt_d = (cnt_q == IW'(TLBNUM - 1)) ? '0 : cnt_q + 1'b1;
   end

   // Free-running counter state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign idx = cnt_q;
`endif

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequencer for LoongArch TLB maintenance ops (tlbsrch/tlbrd/tlbwr/tlbfill/invtlb).
// Takes one op at a time from WB, drives the TLB read/write/invalidate/s1 ports,
// shares s1 with EXE data translation and requests a refetch after every op
// except tlbsrch.
// Build option TLB_FILL_LFSR_EN selects the LFSR fill index in tlb_fill_idx.
module tlb_op_ctrl
   import tlb_pkg::*;
#(
   parameter int unsigned TLBNUM = 16,
   parameter int unsigned IW     = $clog2(TLBNUM)
) (
   input  logic              clk,
   input  logic              resetn,
   // op request from WB
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [2:0]        op_type,
   input  logic [4:0]        op_invop,
   input  logic [9:0]        op_asid,
   input  logic [18:0]       op_vppn,
   input  logic              op_va_bit12,
   input  logic [31:0]       op_pc,
   input  logic [IW-1:0]     csr_tlbidx_index,
   input  logic              ex_flush,
   // EXE data translation
   input  logic              mem_req,
   input  logic [18:0]       mem_vppn,
   input  logic              mem_va_bit12,
   input  logic [9:0]        mem_asid,
   output logic              mem_grant,
   // TLB s1 search port
   output logic [18:0]       s1_vppn,
   output logic              s1_va_bit12,
   output logic [9:0]        s1_asid,
   input  logic              s1_found,
   input  logic [IW-1:0]     s1_index,
   // TLB read/write/invalidate
   output logic [IW-1:0]     r_index,
   output logic              tlb_we,
   output logic [IW-1:0]     w_index,
   output logic              invtlb_valid,
   output logic [4:0]        invtlb_op,
   // completion and refetch
   output logic              op_done,
   output logic              srch_hit,
   output logic [IW-1:0]     srch_index,
   output logic              refetch,
   output logic [31:0]       refetch_pc
);

   tlb_state_e          state_q;
   tlb_state_e          state_d;

   logic                is_fill_q;
   logic [4:0]          invop_q;
   logic [ASID_W-1:0]   asid_q;
   logic [VPPN_W-1:0]   vppn_q;
   logic                va_bit12_q;
   logic [31:0]         refetch_pc_q;
   logic                srch_hit_q;
   logic [IW-1:0]       srch_index_q;
   logic [IW-1:0]       fill_idx;

   logic                accept;
   logic                own_s1;

   assign accept = op_valid & op_ready & ~ex_flush;
   assign own_s1 = (state_q == StSrch) || (state_q == StInv);

   tlb_fill_idx #(
      .TLBNUM (TLBNUM),
      .IW     (IW)
   ) u_fill_idx (
      .clk    (clk),
      .resetn (resetn),
      .idx    (fill_idx)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Latch the op's key, invtlb op and return PC at acceptance.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         is_fill_q    <= 1'b0;
         invop_q      <= '0;
         asid_q       <= '0;
         vppn_q       <= '0;
         va_bit12_q   <= 1'b0;
         refetch_pc_q <= '0;
      end else if (accept) begin
         is_fill_q    <= (op_type == TLBOP_FILL);
         invop_q      <= op_invop;
         asid_q       <= op_asid;
         vppn_q       <= op_vppn;
         va_bit12_q   <= op_va_bit12;
         refetch_pc_q <= op_pc + 32'd4;
      end
   end

   // tlbsrch result holds until the next completed search.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         srch_hit_q   <= 1'b0;
         srch_index_q <= '0;
      end else if ((state_q == StSrch) && !ex_flush) begin
         srch_hit_q   <= s1_found;
         srch_index_q <= s1_index;
      end
   end

   // Next-state: dispatch by op type from IDLE; ex_flush aborts any active op.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               case (op_type)
                  TLBOP_SRCH: state_d = StSrch;
                  TLBOP_RD:   state_d = StRd;
                  TLBOP_WR:   state_d = StWr;
                  TLBOP_FILL: state_d = StWr;
                  TLBOP_INV:  state_d = StInv;
                  default:    state_d = StIdle;
               endcase
            end
         end
         StSrch:  state_d = StIdle;
         StRd:    state_d = StFlush;
         StWr:    state_d = StFlush;
         StInv:   state_d = StFlush;
         StFlush: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if ((state_q != StIdle) && ex_flush) begin
         state_d = StIdle;
      end
   end

   // Outputs: port strobes per state, gated off by ex_flush; s1 arbitration.
   always_comb begin
      op_ready     = (state_q == StIdle);
      r_index      = '0;
      tlb_we       = 1'b0;
      w_index      = '0;
      invtlb_valid = 1'b0;
      invtlb_op    = '0;
      op_done      = 1'b0;
      refetch      = 1'b0;
      refetch_pc   = refetch_pc_q;
      srch_hit     = srch_hit_q;
      srch_index   = srch_index_q;

      if (own_s1) begin
         s1_vppn     = vppn_q;
         s1_va_bit12 = va_bit12_q;
         s1_asid     = asid_q;
         mem_grant   = 1'b0;
      end else begin
         s1_vppn     = mem_vppn;
         s1_va_bit12 = mem_va_bit12;
         s1_asid     = mem_asid;
         mem_grant   = mem_req;
      end

      unique case (state_q)
         StIdle: ;
         StSrch: begin
            op_done = ~ex_flush;
            // Present the live search result alongside op_done.
            if (!ex_flush) begin
               srch_hit   = s1_found;
               srch_index = s1_index;
            end
         end
         StRd: begin
            r_index = csr_tlbidx_index;
            op_done = ~ex_flush;
         end
         StWr: begin
            tlb_we  = ~ex_flush;
            w_index = is_fill_q ? fill_idx : csr_tlbidx_index;
            op_done = ~ex_flush;
         end
         StInv: begin
            invtlb_valid = ~ex_flush;
            invtlb_op    = invop_q;
            op_done      = ~ex_flush;
         end
         StFlush: begin
            refetch = ~ex_flush;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Self-checking bench for tlb_op_ctrl (default build, counter fill index).
// Expected strobe events are queued per cycle when an op is issued and
// compared every cycle at the falling clock edge.
module tb_tlb_op_ctrl;
   import tlb_pkg::*;

   localparam int unsigned TLBNUM = 16;
   localparam int unsigned IW     = 4;

   logic          clk;
   logic          resetn;
   logic          op_valid;
   logic          op_ready;
   logic [2:0]    op_type;
   logic [4:0]    op_invop;
   logic [9:0]    op_asid;
   logic [18:0]   op_vppn;
   logic          op_va_bit12;
   logic [31:0]   op_pc;
   logic [IW-1:0] csr_tlbidx_index;
   logic          ex_flush;
   logic          mem_req;
   logic [18:0]   mem_vppn;
   logic          mem_va_bit12;
   logic [9:0]    mem_asid;
   logic          mem_grant;
   logic [18:0]   s1_vppn;
   logic          s1_va_bit12;
   logic [9:0]    s1_asid;
   logic          s1_found;
   logic [IW-1:0] s1_index;
   logic [IW-1:0] r_index;
   logic          tlb_we;
   logic [IW-1:0] w_index;
   logic          invtlb_valid;
   logic [4:0]    invtlb_op;
   logic          op_done;
   logic          srch_hit;
   logic [IW-1:0] srch_index;
   logic          refetch;
   logic [31:0]   refetch_pc;

   typedef struct packed {
      int          cyc;
      logic        done;
      logic        we;
      logic [3:0]  widx;
      logic        inv;
      logic [4:0]  invop;
      logic        rd;
      logic [3:0]  ridx;
      logic        srch;
      logic        hit;
      logic [3:0]  sidx;
      logic        rf;
      logic [31:0] rpc;
   } exp_t;

   exp_t       sbq[$];
   int         tests;
   int         fails;
   int         cyc;
   logic [3:0] fill_mdl;

   tlb_op_ctrl #(
      .TLBNUM (TLBNUM),
      .IW     (IW)
   ) dut (
      .clk              (clk),
      .resetn           (resetn),
      .op_valid         (op_valid),
      .op_ready         (op_ready),
      .op_type          (op_type),
      .op_invop         (op_invop),
      .op_asid          (op_asid),
      .op_vppn          (op_vppn),
      .op_va_bit12      (op_va_bit12),
      .op_pc            (op_pc),
      .csr_tlbidx_index (csr_tlbidx_index),
      .ex_flush         (ex_flush),
      .mem_req          (mem_req),
      .mem_vppn         (mem_vppn),
      .mem_va_bit12     (mem_va_bit12),
      .mem_asid         (mem_asid),
      .mem_grant        (mem_grant),
      .s1_vppn          (s1_vppn),
      .s1_va_bit12      (s1_va_bit12),
      .s1_asid          (s1_asid),
      .s1_found         (s1_found),
      .s1_index         (s1_index),
      .r_index          (r_index),
      .tlb_we           (tlb_we),
      .w_index          (w_index),
      .invtlb_valid     (invtlb_valid),
      .invtlb_op        (invtlb_op),
      .op_done          (op_done),
      .srch_hit         (srch_hit),
      .srch_index       (srch_index),
      .refetch          (refetch),
      .refetch_pc       (refetch_pc)
   );

   // TLB model: one entry, vppn 0x12345 / asid 0x3, lives at index 7.
   assign s1_found = (s1_vppn == 19'h12345) && (s1_asid == 10'h3);
   assign s1_index = s1_found ? 4'd7 : 4'd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t ev(input int c);
      exp_t e;
      e     = '0;
      e.cyc = c;
      return e;
   endfunction

   // Scoreboard step: compare this cycle against the queue, then advance one clock.
   task automatic sb_cycle();
      exp_t e;
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
         e = sbq.pop_front();
         tests++;
         fails++;
         $display("FAIL sb_missed: event for cycle %0d never compared (now %0d)", e.cyc, cyc);
      end
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
         e = sbq.pop_front();
         tests++;
         if ({op_done, tlb_we, invtlb_valid, refetch} !== {e.done, e.we, e.inv, e.rf} ||
             (e.we && w_index !== e.widx) || (e.inv && invtlb_op !== e.invop) ||
             (e.rd && r_index !== e.ridx) ||
             (e.srch && (srch_hit !== e.hit || srch_index !== e.sidx)) ||
             (e.rf && refetch_pc !== e.rpc)) begin
            fails++;
            $display("FAIL sb_event cyc=%0d got done=%b we=%b widx=%0d inv=%b invop=%0d ridx=%0d hit=%b sidx=%0d rf=%b rpc=%h want done=%b we=%b widx=%0d inv=%b invop=%0d ridx=%0d hit=%b sidx=%0d rf=%b rpc=%h",
                     cyc, op_done, tlb_we, w_index, invtlb_valid, invtlb_op, r_index, srch_hit,
                     srch_index, refetch, refetch_pc, e.done, e.we, e.widx, e.inv, e.invop,
                     e.ridx, e.hit, e.sidx, e.rf, e.rpc);
         end
      end else begin
         tests++;
         if ({op_done, tlb_we, invtlb_valid, refetch} !== 4'b0000) begin
            fails++;
            $display("FAIL sb_quiet cyc=%0d got done/we/inv/rf=%b want 0000", cyc,
                     {op_done, tlb_we, invtlb_valid, refetch});
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      fill_mdl = resetn ? fill_mdl + 4'd1 : 4'd0;
   endtask

   task automatic issue(input logic [2:0] t, input logic [31:0] pc);
      op_valid = 1'b1;
      op_type  = t;
      op_pc    = pc;
   endtask

   task automatic test_reset();
      #2;
      tests++;
      if ({op_ready, op_done, tlb_we, invtlb_valid, refetch, srch_hit} !== 6'b100000) begin
         fails++;
         $display("FAIL reset_flags got %b want 100000",
                  {op_ready, op_done, tlb_we, invtlb_valid, refetch, srch_hit});
      end
      tests++;
      if ({srch_index, w_index, r_index} !== 12'h000 || refetch_pc !== 32'h0) begin
         fails++;
         $display("FAIL reset_idx got sidx=%0d widx=%0d ridx=%0d rpc=%h want 0 0 0 0",
                  srch_index, w_index, r_index, refetch_pc);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      resetn   = 1'b1;
      cyc      = 0;
      fill_mdl = 4'd0;
   endtask

   task automatic test_srch();
      exp_t e;
      // Miss first, then hit, so the held result is non-zero afterwards.
      op_vppn = 19'h00001;
      op_asid = 10'h3;
      e = ev(cyc + 1); e.done = 1; e.srch = 1; e.hit = 0; e.sidx = 4'd0;
      sbq.push_back(e);
      issue(TLBOP_SRCH, 32'h1c00_0000);
      sb_cycle();
      op_valid = 1'b0;
      sb_cycle();
      sb_cycle();

      op_vppn = 19'h12345;
      op_asid = 10'h3;
      e = ev(cyc + 1); e.done = 1; e.srch = 1; e.hit = 1; e.sidx = 4'd7;
      sbq.push_back(e);
      issue(TLBOP_SRCH, 32'h1c00_0010);
      sb_cycle();
      op_valid = 1'b0;
      tests++;
      if (s1_vppn !== 19'h12345 || mem_grant !== 1'b0) begin
         fails++;
         $display("FAIL srch_s1_owner got vppn=%h grant=%b want 12345 0", s1_vppn, mem_grant);
      end
      sb_cycle();
      tests++;
      if (op_ready !== 1'b1) begin
         fails++;
         $display("FAIL srch_ready_n2 got %b want 1", op_ready);
      end
      sb_cycle();
   endtask

   task automatic test_wr_rd();
      exp_t e;
      csr_tlbidx_index = 4'd5;
      e = ev(cyc + 1); e.done = 1; e.we = 1; e.widx = 4'd5;
      sbq.push_back(e);
      e = ev(cyc + 2); e.rf = 1; e.rpc = 32'h1c00_0104;
      sbq.push_back(e);
      issue(TLBOP_WR, 32'h1c00_0100);
      sb_cycle();
      op_valid = 1'b0;
      sb_cycle();
      tests++;
      if (op_ready !== 1'b0) begin
         fails++;
         $display("FAIL wr_ready_flush got %b want 0", op_ready);
      end
      sb_cycle();
      tests++;
      if (op_ready !== 1'b1 || srch_hit !== 1'b1 || srch_index !== 4'd7) begin
         fails++;
         $display("FAIL srch_hold got ready=%b hit=%b sidx=%0d want 1 1 7",
                  op_ready, srch_hit, srch_index);
      end
      // tlbrd at the top of the address space: return PC wraps to 0.
      csr_tlbidx_index = 4'd9;
      e = ev(cyc + 1); e.done = 1; e.rd = 1; e.ridx = 4'd9;
      sbq.push_back(e);
      e = ev(cyc + 2); e.rf = 1; e.rpc = 32'h0000_0000;
      sbq.push_back(e);
      issue(TLBOP_RD, 32'hffff_fffc);
      sb_cycle();
      op_valid = 1'b0;
      sb_cycle();
      sb_cycle();
   endtask

   task automatic test_fill();
      exp_t e;
      logic [31:0] pc;
      csr_tlbidx_index = 4'd9;
      for (int i = 0; i < 40 && fill_mdl != 4'd14; i++) begin
         sb_cycle();
      end
      tests++;
      if (fill_mdl != 4'd14) begin
         fails++;
         $display("FAIL fill_sync got %0d want 14", fill_mdl);
      end
      // Back-to-back fills, three cycles apart: indices 15, 2, 5.
      for (int k = 0; k < 3; k++) begin
         pc = 32'h1c00_0200 + 32'(k * 4);
         e = ev(cyc + 1); e.done = 1; e.we = 1; e.widx = fill_mdl + 4'd1;
         sbq.push_back(e);
         e = ev(cyc + 2); e.rf = 1; e.rpc = pc + 32'd4;
         sbq.push_back(e);
         issue(TLBOP_FILL, pc);
         sb_cycle();
         op_valid = 1'b0;
         sb_cycle();
         sb_cycle();
      end
   endtask

   task automatic test_inv();
      exp_t e;
      mem_req  = 1'b1;
      mem_vppn = 19'h0abcd;
      mem_asid = 10'h02a;
      op_vppn  = 19'h55555;
      op_asid  = 10'h011;
      op_invop = 5'd5;
      e = ev(cyc + 1); e.done = 1; e.inv = 1; e.invop = 5'd5;
      sbq.push_back(e);
      e = ev(cyc + 2); e.rf = 1; e.rpc = 32'h1c00_0304;
      sbq.push_back(e);
      issue(TLBOP_INV, 32'h1c00_0300);
      #1;
      tests++;
      if (mem_grant !== 1'b1 || s1_vppn !== 19'h0abcd || s1_asid !== 10'h02a) begin
         fails++;
         $display("FAIL inv_grant_accept got grant=%b vppn=%h asid=%h want 1 0abcd 02a",
                  mem_grant, s1_vppn, s1_asid);
      end
      sb_cycle();
      op_valid = 1'b0;
      tests++;
      if (mem_grant !== 1'b0 || s1_vppn !== 19'h55555 || s1_asid !== 10'h011) begin
         fails++;
         $display("FAIL inv_grant_op got grant=%b vppn=%h asid=%h want 0 55555 011",
                  mem_grant, s1_vppn, s1_asid);
      end
      sb_cycle();
      tests++;
      if (mem_grant !== 1'b1) begin
         fails++;
         $display("FAIL inv_grant_flush got %b want 1", mem_grant);
      end
      sb_cycle();
      mem_req = 1'b0;
   endtask

   task automatic test_ex_flush();
      csr_tlbidx_index = 4'd5;
      issue(TLBOP_WR, 32'h1c00_0400);
      sb_cycle();
      op_valid = 1'b0;
      ex_flush = 1'b1;
      #1;
      tests++;
      if ({tlb_we, op_done} !== 2'b00) begin
         fails++;
         $display("FAIL exf_strobes got we/done=%b want 00", {tlb_we, op_done});
      end
      sb_cycle();
      ex_flush = 1'b0;
      tests++;
      if (op_ready !== 1'b1 || refetch !== 1'b0) begin
         fails++;
         $display("FAIL exf_idle got ready=%b refetch=%b want 1 0", op_ready, refetch);
      end
      sb_cycle();
      // An op offered while ex_flush is high must not be taken.
      ex_flush = 1'b1;
      issue(TLBOP_WR, 32'h1c00_0500);
      sb_cycle();
      op_valid = 1'b0;
      ex_flush = 1'b0;
      tests++;
      if (op_ready !== 1'b1) begin
         fails++;
         $display("FAIL exf_no_accept got ready=%b want 1", op_ready);
      end
      sb_cycle();
      sb_cycle();
   endtask

   task automatic test_dropped();
      logic [2:0] codes [3];
      codes[0] = 3'd0;
      codes[1] = 3'd6;
      codes[2] = 3'd7;
      for (int k = 0; k < 3; k++) begin
         issue(codes[k], 32'h1c00_0600);
         sb_cycle();
         op_valid = 1'b0;
         tests++;
         if (op_ready !== 1'b1) begin
            fails++;
            $display("FAIL drop_code%0d got ready=%b want 1", codes[k], op_ready);
         end
         sb_cycle();
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      csr_tlbidx_index = 4'd3;
      issue(TLBOP_RD, 32'h1c00_0700);
      sb_cycle();
      op_valid = 1'b0;
      resetn   = 1'b0;
      #1;
      tests++;
      if ({op_ready, op_done, refetch, srch_hit} !== 4'b1000 || r_index !== 4'd0 ||
          refetch_pc !== 32'h0 || srch_index !== 4'd0) begin
         fails++;
         $display("FAIL rst_mid got ready=%b done=%b rf=%b hit=%b ridx=%0d rpc=%h sidx=%0d want 1 0 0 0 0 0 0",
                  op_ready, op_done, refetch, srch_hit, r_index, refetch_pc, srch_index);
      end
      sb_cycle();
      resetn   = 1'b1;
      fill_mdl = 4'd0;
      e = ev(cyc + 1); e.done = 1; e.rd = 1; e.ridx = 4'd3;
      sbq.push_back(e);
      e = ev(cyc + 2); e.rf = 1; e.rpc = 32'h0000_0104;
      sbq.push_back(e);
      issue(TLBOP_RD, 32'h0000_0100);
      sb_cycle();
      op_valid = 1'b0;
      sb_cycle();
      sb_cycle();
   endtask

   initial begin
      tests            = 0;
      fails            = 0;
      cyc              = 0;
      fill_mdl         = 4'd0;
      resetn           = 1'b0;
      op_valid         = 1'b0;
      op_type          = 3'd0;
      op_invop         = 5'd0;
      op_asid          = 10'h0;
      op_vppn          = 19'h0;
      op_va_bit12      = 1'b0;
      op_pc            = 32'h0;
      csr_tlbidx_index = 4'd0;
      ex_flush         = 1'b0;
      mem_req          = 1'b0;
      mem_vppn         = 19'h0;
      mem_va_bit12     = 1'b0;
      mem_asid         = 10'h0;

      test_reset();
      test_srch();
      test_wr_rd();
      test_fill();
      test_inv();
      test_ex_flush();
      test_dropped();
      test_reset_mid();

      tests++;
      if (sbq.size() != 0) begin
         fails++;
         $display("FAIL sb_leftover got %0d pending events want 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
